if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised successor to the single-entry fetch stage.
- Decouples PC generation from decode using an in-order instruction queue.
- Keeps up to MAX_OUTSTANDING pipelined requests in flight to instruction memory, and discards stale responses on redirect.
- Sits between the instruction memory/cache port and the ID stage; ID consumes instructions through a valid/ready handshake.

Parameters:
- RESET_ADDR, 32'h00000000: PC of the first fetch after reset.
- DEPTH, 4: number of queue entries; power of two, at least 2.
- MAX_OUTSTANDING, 2: maximum number of accepted but not yet returned memory requests; range 1 to DEPTH.

Ports:
- i_clk  in  1  global clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_redirect  in  1  flush the queue and restart fetch at i_redirect_target.
- i_redirect_target  in  32  new PC; bits [1:0] are ignored and treated as 0.
- o_imem_req  out  1  fetch request valid.
- o_imem_addr  out  32  word-aligned fetch address.
- i_imem_gnt  in  1  memory accepts the request this cycle.
- i_imem_rvalid  in  1  response valid; responses return in request order.
- i_imem_rdata  in  32  response instruction word.
- o_valid  out  1  queue head is valid.
- o_inst  out  32  instruction at the queue head.
- o_pc  out  32  PC of o_inst.
- o_pc_plus_4  out  32  o_pc + 4, modulo 2^32.
- i_ready  in  1  ID consumes the head this cycle.
- o_empty  out  1  queue holds no entries.

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_ADDR, queue count=0, outstanding=0, drop=0. Outputs: o_imem_req=0, o_valid=0, o_inst=0, o_pc=RESET_ADDR, o_empty=1.
- Request rule: o_imem_req=1 when all of the following hold:
  - outstanding < MAX_OUTSTANDING
  - count + outstanding < DEPTH, which guarantees a slot for every in-flight response
  - i_redirect=0
- o_imem_addr = fetch_pc whenever a request is driven.
- Handshake: fire = o_imem_req & i_imem_gnt. On fire, fetch_pc += 4 and outstanding += 1.
  - Once raised, o_imem_req and the address hold stable until gnt or redirect.
- Response: on i_imem_rvalid, outstanding -= 1.
  - If drop>0: the response is discarded and drop -= 1.
  - Otherwise: {rdata, pc} is written at the tail. The stored PC comes from an internal pc-tag FIFO loaded at fire.
- Latency:
  - First o_imem_req is asserted in the first cycle after reset release.
  - A written response is visible on o_valid the cycle after i_imem_rvalid; there is no bypass.
  - With gnt tied high and 1-cycle memory, the first instruction is visible 3 cycles after reset release.
- Dequeue: o_valid & i_ready pops the head. A push and a pop in the same cycle leave count unchanged.
- Full: count==DEPTH with i_ready=0 means no new fires. Overflow is impossible by construction. Queue pointers wrap modulo DEPTH.
- Redirect (has priority over everything else):
  - Same cycle: o_imem_req=0 and a pop is still permitted but irrelevant.
  - Next edge: queue cleared (count=0), fetch_pc=target, drop = outstanding in flight after this cycle's response and fire accounting. A response in the redirect cycle is itself discarded and not counted. A fire in the redirect cycle cannot occur because o_imem_req is forced to 0.
  - o_valid=0 in the cycle following a redirect.
- Back-to-back redirects: the last one wins, and drop accumulates correctly.
- Counters are sized $clog2(DEPTH+1) bits. PC wraps at 2^32 with no error.

Optional Feature:
- IF_FETCH_PERF_EN adds three ports: o_perf_fetched (32), o_perf_dropped (32), o_perf_starve (32).
- Counter behaviour:
  - o_perf_fetched: increments per instruction enqueued.
  - o_perf_dropped: increments per discarded response.
  - o_perf_starve: increments per cycle with o_valid=0 and i_ready=1.
- All three reset to 0 and saturate at 32'hFFFFFFFF.
- Without the macro the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, gnt=1, 1-cycle memory, i_ready=1: o_pc sequence is 0x0, 0x4, 0x8, ... with one instruction per cycle from cycle 3, and o_imem_req never drops.
- i_ready=0 with DEPTH=4, MAX_OUTSTANDING=2: exactly 4 fires, o_empty=0, queue full, then o_imem_req=0. Raising i_ready drains 0x0 to 0xC in order.
- Redirect to 0x100 with 2 requests outstanding: both responses are discarded, and the next o_valid carries o_pc=0x100 with o_pc_plus_4=0x104.
- i_imem_gnt held low for 5 cycles: o_imem_req and o_imem_addr (0x8) remain stable. After gnt, fetch continues at 0xC.
- Redirect coinciding with i_imem_rvalid, followed by a second redirect to 0x200 on the next cycle: only 0x200 and later instructions appear, and no stale data leaks through.
- Async reset asserted mid-stream with queue non-empty: o_valid=0, o_imem_req=0, and o_empty=1 immediately with no clock edge. Fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: pipelined imem requests feed an in-order instruction queue drained by ID.
// Define IF_FETCH_PERF_EN to add the fetched/dropped/starve performance counters.
module if_fetch_queue #(
  parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus_4,
  input  logic        i_ready,
  output logic        o_empty
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] o_perf_fetched,
  output logic [31:0] o_perf_dropped,
  output logic [31:0] o_perf_starve
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      fetch_pc;
  logic             run;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] drop;
  logic [CNT_W:0]   occupancy;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] tag_wr;
  logic [PTR_W-1:0] tag_rd;
  logic             fire;
  logic             discard;
  logic             push;
  logic             pop;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] tag_mem  [DEPTH];

  // Reserving a queue slot for every in-flight request is what makes overflow impossible.
  assign occupancy  = {1'b0, count} + {1'b0, outstanding};
  assign o_imem_req = run && (outstanding < MAX_C) && (occupancy < DEPTH_C) && !i_redirect;
  assign o_imem_addr = fetch_pc;

  assign fire    = o_imem_req && i_imem_gnt;
  assign discard = i_imem_rvalid && (i_redirect || (drop != '0));
  assign push    = i_imem_rvalid && !discard;
  assign pop     = o_valid && i_ready;

  assign outstanding_next = outstanding + CNT_W'(fire) - CNT_W'(i_imem_rvalid);

  assign o_valid     = (count != '0);
  assign o_empty     = (count == '0);
  assign o_inst      = o_valid ? inst_mem[head] : 32'h0;
  assign o_pc        = o_valid ? pc_mem[head] : fetch_pc;
  assign o_pc_plus_4 = o_pc + 32'd4;

  // NOTE: state registers use non-blocking <= so every update sees the pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_ADDR;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      head        <= '0;
      tail        <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding_next;
      if (fire)          tag_wr <= tag_wr + PTR_W'(1);
      if (i_imem_rvalid) tag_rd <= tag_rd + PTR_W'(1);
      if (i_redirect) begin
        // Everything still in flight belongs to the old path and must be dropped.
        fetch_pc <= i_redirect_target & ~32'd3;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        drop     <= outstanding_next;
      end else begin
        if (fire)    fetch_pc <= fetch_pc + 32'd4;
        if (discard) drop     <= drop - CNT_W'(1);
        if (push)    tail     <= tail + PTR_W'(1);
        if (pop)     head     <= head + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // NOTE: storage arrays are not reset; count and pointers qualify every read, so stale contents are never observed.
  always_ff @(posedge i_clk) begin
    if (fire) tag_mem[tag_wr] <= fetch_pc;
    if (push) begin
      inst_mem[tail] <= i_imem_rdata;
      pc_mem[tail]   <= tag_mem[tag_rd];
    end
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_perf_fetched <= '0;
      o_perf_dropped <= '0;
      o_perf_starve  <= '0;
    end else begin
      if (push && o_perf_fetched != '1)                 o_perf_fetched <= o_perf_fetched + 32'd1;
      if (discard && o_perf_dropped != '1)              o_perf_dropped <= o_perf_dropped + 32'd1;
      if (!o_valid && i_ready && o_perf_starve != '1)   o_perf_starve  <= o_perf_starve + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: in-order memory model plus an instruction-stream reference model.
module tb_if_fetch_queue;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam int          DEPTH      = 4;
  localparam int          MAX_OUT    = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_target = '0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus_4;
  logic        i_ready = 1'b0;
  logic        o_empty;

  if_fetch_queue #(
    .RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_redirect(i_redirect), .i_redirect_target(i_redirect_target),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_valid(o_valid), .o_inst(o_inst), .o_pc(o_pc), .o_pc_plus_4(o_pc_plus_4),
    .i_ready(i_ready), .o_empty(o_empty)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle stimulus knobs
  logic        gnt_k, ready_k, redir_k;
  logic [31:0] target_k;
  int          lat_k;

  // Memory model: in-order pending requests with the cycle their response becomes available
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;

  // Reference model: next PC the ID stage should see, next address the fetcher should request
  logic [31:0] exp_pc, exp_fetch;

  logic        s_req, s_valid, s_empty;
  logic [31:0] s_addr, s_pc, s_inst, s_pc4;
  logic        prev_req, prev_gnt, prev_redir;
  logic [31:0] prev_addr;
  int          nfire, npop;
  logic        saw_zero;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_redirect = 1'b0; i_redirect_target = '0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0; i_ready = 1'b0;
    redir_k = 1'b0; target_k = '0; gnt_k = 1'b1; ready_k = 1'b1; lat_k = 1;
    pend_addr.delete(); pend_due.delete();
    exp_pc = RESET_ADDR; exp_fetch = RESET_ADDR;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_redir = 1'b0; prev_addr = '0;
    nfire = 0; npop = 0; saw_zero = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs at the falling edge, sample and check, then advance the models.
  task automatic step();
    logic        rv, fire, pop;
    logic [31:0] rd;
    rv = 1'b0; rd = '0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      rv = 1'b1; rd = inst_of(pend_addr[0]);
    end
    i_imem_rvalid = rv; i_imem_rdata = rd;
    i_imem_gnt = gnt_k; i_ready = ready_k;
    i_redirect = redir_k; i_redirect_target = target_k;
    #1;
    s_req = o_imem_req; s_addr = o_imem_addr; s_valid = o_valid; s_empty = o_empty;
    s_pc = o_pc; s_inst = o_inst; s_pc4 = o_pc_plus_4;

    n_checks++;
    if (s_empty !== !s_valid) begin
      n_errors++; $display("FAIL empty_vs_valid: o_empty=%b o_valid=%b", s_empty, s_valid);
    end
    if (redir_k) begin
      n_checks++;
      if (s_req !== 1'b0) begin n_errors++; $display("FAIL req_on_redirect: got %b expected 0", s_req); end
    end
    if (prev_redir) begin
      n_checks++;
      if (s_valid !== 1'b0) begin n_errors++; $display("FAIL valid_after_redirect: got %b expected 0", s_valid); end
    end
    if (prev_req && !prev_gnt && !prev_redir && !redir_k) begin
      n_checks++;
      if (s_req !== 1'b1 || s_addr !== prev_addr) begin
        n_errors++; $display("FAIL req_stable: req=%b addr=%h expected req=1 addr=%h", s_req, s_addr, prev_addr);
      end
    end

    fire = s_req && gnt_k;
    pop  = s_valid && ready_k && !redir_k;
    if (fire) begin
      n_checks++;
      if (s_addr !== exp_fetch) begin n_errors++; $display("FAIL fetch_addr: got %h expected %h", s_addr, exp_fetch); end
      exp_fetch = exp_fetch + 32'd4;
      nfire++;
    end
    if (pop) begin
      n_checks++;
      if (s_pc !== exp_pc || s_inst !== inst_of(exp_pc) || s_pc4 !== exp_pc + 32'd4) begin
        n_errors++;
        $display("FAIL head: pc=%h inst=%h pc4=%h expected pc=%h inst=%h pc4=%h",
                 s_pc, s_inst, s_pc4, exp_pc, inst_of(exp_pc), exp_pc + 32'd4);
      end
      if (s_pc == 32'h0) saw_zero = 1'b1;
      exp_pc = exp_pc + 32'd4;
      npop++;
    end
    if (redir_k) begin
      exp_pc    = target_k & ~32'd3;
      exp_fetch = target_k & ~32'd3;
    end

    @(posedge i_clk);
    cyc++;
    if (rv) begin
      void'(pend_addr.pop_front()); void'(pend_due.pop_front());
    end
    if (fire) begin
      pend_addr.push_back(s_addr); pend_due.push_back(cyc + lat_k - 1);
      n_checks++;
      if (pend_addr.size() > MAX_OUT) begin
        n_errors++; $display("FAIL outstanding: got %0d limit %0d", pend_addr.size(), MAX_OUT);
      end
    end
    prev_req = s_req; prev_gnt = gnt_k; prev_redir = redir_k; prev_addr = s_addr;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    #1 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_imem_req !== 1'b0 || o_valid !== 1'b0 || o_inst !== 32'h0 || o_pc !== RESET_ADDR || o_empty !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_state: req=%b valid=%b inst=%h pc=%h empty=%b expected 0 0 0 %h 1",
               o_imem_req, o_valid, o_inst, o_pc, o_empty, RESET_ADDR);
    end
  endtask

  task automatic test_stream();
    do_reset();
    gnt_k = 1'b1; ready_k = 1'b1; lat_k = 1;
    for (int k = 0; k < 14; k++) begin
      step();
      if (k >= 1) begin
        n_checks++;
        if (s_req !== 1'b1) begin n_errors++; $display("FAIL stream_req k=%0d: got %b expected 1", k, s_req); end
      end
      if (k < 3) begin
        n_checks++;
        if (s_valid !== 1'b0) begin n_errors++; $display("FAIL stream_early_valid k=%0d: got %b expected 0", k, s_valid); end
      end else begin
        n_checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'((k - 3) * 4)) begin
          n_errors++; $display("FAIL stream_pc k=%0d: valid=%b pc=%h expected 1 %h", k, s_valid, s_pc, 32'((k - 3) * 4));
        end
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    gnt_k = 1'b1; ready_k = 1'b0; lat_k = 1;
    repeat (10) step();
    n_checks++;
    if (nfire != DEPTH) begin n_errors++; $display("FAIL full_fires: got %0d expected %0d", nfire, DEPTH); end
    n_checks++;
    if (s_req !== 1'b0 || s_empty !== 1'b0 || s_valid !== 1'b1) begin
      n_errors++; $display("FAIL full_state: req=%b empty=%b valid=%b expected 0 0 1", s_req, s_empty, s_valid);
    end
    ready_k = 1'b1;
    repeat (8) step();
    n_checks++;
    if (npop < DEPTH) begin n_errors++; $display("FAIL full_drain: got %0d pops expected at least %0d", npop, DEPTH); end
  endtask

  task automatic test_redirect();
    logic found;
    do_reset();
    gnt_k = 1'b1; ready_k = 1'b1; lat_k = 3;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (pend_addr.size() == 2) found = 1'b1; else step();
    end
    n_checks++;
    if (!found) begin n_errors++; $display("FAIL redirect_setup: outstanding got %0d expected 2", pend_addr.size()); end
    redir_k = 1'b1; target_k = 32'h100;
    step();
    redir_k = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (s_valid) found = 1'b1;
    end
    n_checks++;
    if (!found || s_pc !== 32'h100 || s_pc4 !== 32'h104) begin
      n_errors++; $display("FAIL redirect_target: valid=%b pc=%h pc4=%h expected 1 00000100 00000104", found, s_pc, s_pc4);
    end
  endtask

  task automatic test_gnt_stall();
    do_reset();
    gnt_k = 1'b1; ready_k = 1'b1; lat_k = 1;
    repeat (3) step();
    gnt_k = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h8) begin
        n_errors++; $display("FAIL stall_hold k=%0d: req=%b addr=%h expected 1 00000008", k, s_req, s_addr);
      end
    end
    gnt_k = 1'b1;
    step();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h8) begin
      n_errors++; $display("FAIL stall_release: req=%b addr=%h expected 1 00000008", s_req, s_addr);
    end
    step();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 32'hC) begin
      n_errors++; $display("FAIL stall_next: req=%b addr=%h expected 1 0000000c", s_req, s_addr);
    end
    repeat (6) step();
  endtask

  task automatic test_double_redirect();
    logic found;
    do_reset();
    gnt_k = 1'b1; ready_k = 1'b1; lat_k = 1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) found = 1'b1; else step();
    end
    n_checks++;
    if (!found) begin n_errors++; $display("FAIL dbl_setup: no response pending got %0d expected 1", 0); end
    redir_k = 1'b1; target_k = 32'h180;
    step();
    target_k = 32'h200;
    step();
    redir_k = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (s_valid) found = 1'b1;
    end
    n_checks++;
    if (!found || s_pc !== 32'h200) begin
      n_errors++; $display("FAIL dbl_redirect: valid=%b pc=%h expected 1 00000200", found, s_pc);
    end
    repeat (8) step();
  endtask

  task automatic test_wrap();
    logic found;
    do_reset();
    gnt_k = 1'b1; ready_k = 1'b1; lat_k = 2;
    repeat (3) step();
    redir_k = 1'b1; target_k = 32'hFFFF_FFFA;
    step();
    redir_k = 1'b0;
    saw_zero = 1'b0; npop = 0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (s_valid) found = 1'b1;
    end
    n_checks++;
    if (!found || s_pc !== 32'hFFFF_FFF8 || s_pc4 !== 32'hFFFF_FFFC) begin
      n_errors++; $display("FAIL wrap_first: valid=%b pc=%h pc4=%h expected 1 fffffff8 fffffffc", found, s_pc, s_pc4);
    end
    repeat (12) step();
    n_checks++;
    if (!saw_zero || npop < 3) begin
      n_errors++; $display("FAIL wrap_cross: saw_zero=%b pops=%0d expected 1 and at least 3", saw_zero, npop);
    end
  endtask

  task automatic test_async_reset();
    logic found;
    do_reset();
    gnt_k = 1'b1; ready_k = 1'b0; lat_k = 1;
    repeat (6) step();
    n_checks++;
    if (s_valid !== 1'b1) begin n_errors++; $display("FAIL async_pre: valid=%b expected 1", s_valid); end
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_imem_req !== 1'b0 || o_empty !== 1'b1 || o_pc !== RESET_ADDR) begin
      n_errors++; $display("FAIL async_reset: valid=%b req=%b empty=%b pc=%h expected 0 0 1 %h",
                           o_valid, o_imem_req, o_empty, o_pc, RESET_ADDR);
    end
    do_reset();
    gnt_k = 1'b1; ready_k = 1'b1; lat_k = 1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (s_valid) found = 1'b1;
    end
    n_checks++;
    if (!found || s_pc !== RESET_ADDR) begin
      n_errors++; $display("FAIL async_restart: valid=%b pc=%h expected 1 %h", found, s_pc, RESET_ADDR);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      gnt_k   = ($urandom_range(0, 3) != 0);
      ready_k = ($urandom_range(0, 2) != 0);
      lat_k   = $urandom_range(1, 4);
      redir_k = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 2))
        0:       target_k = $urandom;
        1:       target_k = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: target_k = $urandom & 32'hFFF;
      endcase
      step();
    end
    redir_k = 1'b0;
    n_checks++;
    if (npop < 100) begin n_errors++; $display("FAIL random_progress: got %0d pops expected at least 100", npop); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_gnt_stall();
    test_double_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
